// File: rtl/seg_mux_capture.sv
// ============================================================================
// Module      : seg_mux_capture
// Description : Recovers hex digits from a multiplexed seven-segment bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_mux_capture #(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 100000
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic [6:0] LEDout,
    input  logic       AN0,
    input  logic       AN1,
    input  logic       AN2,
    input  logic       AN3,
    output logic [3:0] SN0,
    output logic [3:0] SN1,
    output logic [3:0] SN2,
    output logic [3:0] SN3,
    output logic [3:0] dig_valid,
    output logic       upd,
    output logic [1:0] upd_idx,
    output logic       bad_seg,
    output logic       bad_an,
    output logic       lost
);

    localparam logic [7:0]  c_settle   = 8'(SETTLE);
    localparam logic [23:0] c_timeout  = 24'(TIMEOUT);
    localparam logic [1:0]  c_idle     = 2'd0;
    localparam logic [1:0]  c_settling = 2'd1;
    localparam logic [1:0]  c_held     = 2'd2;

    logic [10:0] r_s1, r_s2;
    logic [7:0]  r_cnt;
    logic [23:0] r_to;
    logic [1:0]  r_state, w_state_next;
    logic [3:0]  r_sn [4];
    logic [3:0]  r_valid;
    logic        r_upd, r_bad_seg, r_bad_an, r_lost;
    logic [1:0]  r_upd_idx;

    logic        w_change, w_new_active, w_fire, w_legal, w_single;
    logic        w_capture, w_seg_err, w_an_err, w_expire;
    logic [3:0]  w_nib, w_low, w_onehot;
    logic [1:0]  w_idx;

    // Change is seen as s2 is about to take a new value, so the dwell
    // needed before capture includes the sample still in the first stage.
    assign w_change     = (r_s1 != r_s2);
    assign w_new_active = (r_s1[10:7] != 4'hF);
    assign w_expire     = (r_to >= c_timeout - 24'd1);

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_s1  <= '1;
            r_s2  <= '1;
            r_cnt <= 8'd0;
        end else begin
            r_s1 <= {AN3, AN2, AN1, AN0, LEDout};
            r_s2 <= r_s1;
            if (w_change)
                r_cnt <= 8'd0;
            else if (r_cnt != c_settle)
                r_cnt <= r_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst)
            r_state <= c_idle;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (w_change)
            w_state_next = w_new_active ? c_settling : c_idle;
        else if (r_state == c_settling && w_fire)
            w_state_next = c_held;
    end

    always_comb begin
        w_fire = (r_state == c_settling) && !w_change && (r_cnt + 8'd1 == c_settle);
        w_low  = ~r_s2[10:7];
        w_single = 1'b1;
        w_idx    = 2'd0;
        case (w_low)
            4'b0001: w_idx = 2'd0;
            4'b0010: w_idx = 2'd1;
            4'b0100: w_idx = 2'd2;
            4'b1000: w_idx = 2'd3;
            default: w_single = 1'b0;
        endcase
        w_legal = 1'b1;
        w_nib   = 4'h0;
        case (r_s2[6:0])
            7'h01: w_nib = 4'h0;
            7'h4F: w_nib = 4'h1;
            7'h12: w_nib = 4'h2;
            7'h06: w_nib = 4'h3;
            7'h4C: w_nib = 4'h4;
            7'h24: w_nib = 4'h5;
            7'h20: w_nib = 4'h6;
            7'h0F: w_nib = 4'h7;
            7'h00: w_nib = 4'h8;
            7'h04: w_nib = 4'h9;
            7'h08: w_nib = 4'hA;
            7'h60: w_nib = 4'hB;
            7'h31: w_nib = 4'hC;
            7'h42: w_nib = 4'hD;
            7'h30: w_nib = 4'hE;
            7'h38: w_nib = 4'hF;
            default: w_legal = 1'b0;
        endcase
        w_capture = w_fire && w_single && w_legal;
        w_seg_err = w_fire && w_single && !w_legal;
        w_an_err  = w_fire && !w_single;
        w_onehot  = 4'b0001 << w_idx;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) r_sn[i] <= 4'h0;
            r_valid   <= 4'b0000;
            r_upd     <= 1'b0;
            r_upd_idx <= 2'd0;
            r_bad_seg <= 1'b0;
            r_bad_an  <= 1'b0;
            r_lost    <= 1'b0;
            r_to      <= 24'd0;
        end else begin
            r_upd <= w_capture;
            if (w_seg_err) r_bad_seg <= 1'b1;
            if (w_an_err)  r_bad_an  <= 1'b1;
            if (w_capture) begin
                r_sn[w_idx] <= w_nib;
                r_upd_idx   <= w_idx;
                r_lost      <= 1'b0;
                r_to        <= 24'd0;
                // A capture coinciding with expiry keeps only its own digit.
                r_valid     <= (w_expire ? 4'b0000 : r_valid) | w_onehot;
            end else begin
                if (r_to != c_timeout) r_to <= r_to + 24'd1;
                if (w_expire) begin
                    r_valid <= 4'b0000;
                    r_lost  <= 1'b1;
                end
            end
        end
    end

    assign SN0       = r_sn[0];
    assign SN1       = r_sn[1];
    assign SN2       = r_sn[2];
    assign SN3       = r_sn[3];
    assign dig_valid = r_valid;
    assign upd       = r_upd;
    assign upd_idx   = r_upd_idx;
    assign bad_seg   = r_bad_seg;
    assign bad_an    = r_bad_an;
    assign lost      = r_lost;

endmodule

`default_nettype wire

// File: tb/tb_seg_mux_capture.sv
// ============================================================================
// Module      : tb_seg_mux_capture
// Description : Self-checking bench for seg_mux_capture against a dwell model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_mux_capture;

    localparam int S  = 4;
    localparam int TO = 50;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] led;
    logic [3:0] an;
    logic [3:0] sn0, sn1, sn2, sn3, dig_valid;
    logic       upd, bad_seg, bad_an, lost;
    logic [1:0] upd_idx;

    always #5 clk = ~clk;

    seg_mux_capture #(.SETTLE(S), .TIMEOUT(TO)) u_dut (
        .clk_in(clk), .rst(rst), .LEDout(led),
        .AN0(an[0]), .AN1(an[1]), .AN2(an[2]), .AN3(an[3]),
        .SN0(sn0), .SN1(sn1), .SN2(sn2), .SN3(sn3),
        .dig_valid(dig_valid), .upd(upd), .upd_idx(upd_idx),
        .bad_seg(bad_seg), .bad_an(bad_an), .lost(lost)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: a digit is captured once its pattern has been seen
    // on SETTLE+1 consecutive edges, acted on one edge later.
    logic [6:0]  seg_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                  7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
    logic [10:0] hist [$];
    logic [3:0]  m_sn [4];
    logic [3:0]  m_valid;
    logic        m_upd, m_bseg, m_ban, m_lost;
    logic [1:0]  m_idx;
    int          m_since;

    int cyc = 0, n_upd = 0, upd_cyc = 0, lost_cyc = 0;
    logic prev_lost = 1'b0;

    function automatic int decode(input logic [6:0] s);
        for (int k = 0; k < 16; k++)
            if (seg_tab[k] == s) return k;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_sn[i] = 4'h0;
        m_valid = 4'b0; m_upd = 0; m_idx = 0; m_bseg = 0; m_ban = 0; m_lost = 0; m_since = 0;
    endtask

    task automatic model_edge();
        logic [10:0] p;
        logic [3:0]  low;
        int n, d, idx;
        bit stable, cap;
        if (rst) begin
            hist.push_back(11'h7FF);
            model_reset();
        end else begin
            hist.push_back({an, led});
            n = hist.size() - 1;
            p = hist[n-1];
            stable = (hist[n-S-2] != p);
            for (int k = n - S - 1; k <= n - 1; k++)
                if (hist[k] != p) stable = 0;
            low = ~p[10:7];
            cap = 0; d = 0; idx = 0;
            m_upd = 0;
            if (stable && low != 4'b0) begin
                if ($countones(low) == 1) begin
                    d = decode(p[6:0]);
                    for (int i = 0; i < 4; i++) if (low[i]) idx = i;
                    if (d >= 0) cap = 1; else m_bseg = 1;
                end else begin
                    m_ban = 1;
                end
            end
            if (cap) begin
                if (m_since + 1 >= TO) m_valid = 4'b0;
                m_valid[idx] = 1'b1;
                m_sn[idx]    = d[3:0];
                m_idx        = idx[1:0];
                m_upd        = 1;
                m_lost       = 0;
                m_since      = 0;
            end else begin
                if (m_since < TO) m_since++;
                if (m_since >= TO) begin
                    m_valid = 4'b0;
                    m_lost  = 1;
                end
            end
        end
        while (hist.size() > S + 3) void'(hist.pop_front());
    endtask

    function automatic logic [31:0] obs_vec();
        return 32'({sn3, sn2, sn1, sn0, dig_valid, upd, upd_idx, bad_seg, bad_an, lost});
    endfunction

    function automatic logic [31:0] exp_vec();
        return 32'({m_sn[3], m_sn[2], m_sn[1], m_sn[0], m_valid, m_upd, m_idx, m_bseg, m_ban, m_lost});
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        chk("cycle_state", obs_vec(), exp_vec());
        if (upd) begin n_upd++; upd_cyc = cyc; end
        if (lost && !prev_lost) lost_cyc = cyc;
        prev_lost = lost;
    endtask

    task automatic drive(input logic [3:0] a, input logic [6:0] l, input int cycles);
        an = a; led = l;
        repeat (cycles) tick();
    endtask

    initial begin
        int base, r, dw;
        logic [3:0] ra;
        logic [6:0] rl;
        for (int i = 0; i < S + 3; i++) hist.push_back(11'h7FF);
        model_reset();
        rst = 1'b1; an = 4'hF; led = 7'h7F;
        tick(); tick();
        chk("reset_state", obs_vec(), 32'h0);
        rst = 1'b0;

        // Basic capture: upd exactly at edge SETTLE+2, once.
        n_upd = 0; an = 4'b1110; led = 7'h12;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == S + 2) chk("basic_upd_edge", 32'(upd), 32'h1);
        end
        chk("basic_sn0", 32'(sn0), 32'h2);
        chk("basic_valid", 32'(dig_valid), 32'h1);
        chk("basic_upd_count", 32'(n_upd), 32'h1);
        drive(4'hF, 7'h7F, 2);

        // Full scan of digits 1..3.
        n_upd = 0;
        drive(4'b1101, 7'h4F, 8); drive(4'hF, 7'h7F, 2);
        drive(4'b1011, 7'h38, 8); drive(4'hF, 7'h7F, 2);
        drive(4'b0111, 7'h00, 8); drive(4'hF, 7'h7F, 2);
        chk("scan_digits", 32'({sn3, sn2, sn1, sn0}), 32'h8F12);
        chk("scan_valid", 32'(dig_valid), 32'hF);
        chk("scan_upd_count", 32'(n_upd), 32'h3);

        // Glitch rejection: 4-cycle dwell ignored, 6-cycle dwell captured.
        n_upd = 0;
        drive(4'b1101, 7'h06, 4); drive(4'hF, 7'h7F, 4);
        chk("glitch_no_upd", 32'(n_upd), 32'h0);
        chk("glitch_sn1_kept", 32'(sn1), 32'h1);
        drive(4'b1101, 7'h06, 6); drive(4'hF, 7'h7F, 4);
        chk("dwell6_sn1", 32'(sn1), 32'h3);

        // Illegal segment pattern, then two anodes low.
        n_upd = 0;
        drive(4'b1011, 7'h7F, 10); drive(4'hF, 7'h7F, 2);
        chk("bad_seg_set", 32'(bad_seg), 32'h1);
        drive(4'b1100, 7'h01, 10); drive(4'hF, 7'h7F, 2);
        chk("bad_an_set", 32'(bad_an), 32'h1);
        chk("illegal_no_upd", 32'(n_upd), 32'h0);
        chk("illegal_sn_kept", 32'({sn1, sn0}), 32'h32);

        // Timeout: lost exactly TO cycles after the upd cycle.
        drive(4'b1110, 7'h4F, 8);
        base = upd_cyc;
        drive(4'hF, 7'h7F, 60);
        chk("timeout_distance", 32'(lost_cyc - base), 32'(TO));
        chk("timeout_valid", 32'({dig_valid, lost}), 32'h1);
        chk("timeout_sn_kept", 32'({sn3, sn2, sn1, sn0}), 32'h8F31);
        drive(4'b0111, 7'h0F, 8);
        chk("recapture_valid", 32'({dig_valid, lost}), 32'h10);
        chk("flags_sticky", 32'({bad_seg, bad_an}), 32'h3);

        // Reset at cycle 3 of a dwell; capture SETTLE+2 edges after release.
        an = 4'b1101; led = 7'h24;
        tick(); tick();
        rst = 1'b1; tick();
        chk("rst_mid_state", obs_vec(), 32'h0);
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == S + 1) chk("rst_mid_no_early", 32'(upd), 32'h0);
            if (k == S + 2) chk("rst_mid_capture", 32'({upd, sn1}), 32'h15);
        end

        // Randomized traffic against the model.
        for (int it = 0; it < 250; it++) begin
            r  = $urandom_range(0, 19);
            ra = 4'hF;
            ra[$urandom_range(0, 3)] = 1'b0;
            rl = seg_tab[$urandom_range(0, 15)];
            dw = $urandom_range(1, 8);
            if (r == 0) begin ra = 4'hF; dw = $urandom_range(1, 60); end
            else if (r == 1) ra = 4'($urandom);
            else if (r == 2) rl = 7'($urandom);
            if ($urandom_range(0, 40) == 0) begin
                rst = 1'b1; tick(); rst = 1'b0;
            end
            drive(ra, rl, dw);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
